// File: rtl/instr_decode.sv
// Fetch/decode front end: requests one instruction at a time, decodes it into fields and
// hands it to the execute stage over a valid/ready handshake, with redirect and bus-error halt.
module instr_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_fetch,
    output logic [31:0] o_pc,
    input  logic [47:0] i_instruction,
    input  logic        i_valid,
    input  logic        i_error,
    output logic        o_dec_valid,
    input  logic        i_dec_ready,
    output logic [4:0]  o_op,
    output logic [2:0]  o_cc,
    output logic [3:0]  o_ra,
    output logic [3:0]  o_rb,
    output logic [31:0] o_imm,
    output logic [2:0]  o_len,
    output logic [31:0] o_dec_pc,
    output logic        o_illegal,
    input  logic        i_jump,
    input  logic [31:0] i_jump_pc,
    output logic        o_halted
);

    // The fetch pulse is registered on leaving FETCH, so it is high during the GAP cycle.
    typedef enum logic [2:0] {FETCH, GAP, WAIT, OUT, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] pc_next;
    logic        fetch_next, dec_valid_next, capture;
    logic [2:0]  amode;
    logic [3:0]  rb_dec;
    logic [31:0] imm_dec;
    logic [2:0]  len_dec;
    logic        illegal_dec;
    logic        unused_bits;

    assign amode       = i_instruction[35:33];
    assign unused_bits = ^{i_instruction[32], i_jump_pc[0]};

    always_comb begin
        rb_dec      = 4'd0;
        imm_dec     = 32'd0;
        len_dec     = 3'd2;
        illegal_dec = 1'b0;
        case (amode)
            3'b000: ;
            3'b001: begin
                len_dec = 3'd4;
                rb_dec  = i_instruction[31:28];
                imm_dec = {{20{i_instruction[27]}}, i_instruction[27:16]};
            end
            3'b010: begin
                len_dec = 3'd6;
                rb_dec  = i_instruction[31:28];
                imm_dec = {{4{i_instruction[27]}}, i_instruction[27:0]};
            end
            3'b011: begin
                len_dec = 3'd6;
                imm_dec = i_instruction[31:0];
            end
            default: illegal_dec = 1'b1;
        endcase
    end

    always_comb begin
        state_next     = state;
        pc_next        = o_pc;
        fetch_next     = 1'b0;
        dec_valid_next = o_dec_valid;
        capture        = 1'b0;
        case (state)
            FETCH: begin
                state_next = GAP;
                fetch_next = 1'b1;
            end
            GAP:   state_next = WAIT;
            WAIT: begin
                if (i_error) begin
                    state_next = HALT;
                end else if (i_valid) begin
                    state_next     = OUT;
                    dec_valid_next = 1'b1;
                    capture        = 1'b1;
                end
            end
            OUT: begin
                if (o_dec_valid && i_dec_ready) begin
                    pc_next        = o_dec_pc + {29'd0, o_len};
                    state_next     = FETCH;
                    dec_valid_next = 1'b0;
                end
            end
            HALT:    dec_valid_next = 1'b0;
            default: state_next = FETCH;
        endcase
        // A redirect beats everything except a halt already taken or a bus error in WAIT.
        if (i_jump && state != HALT && !(state == WAIT && i_error)) begin
            pc_next        = {i_jump_pc[31:1], 1'b0};
            state_next     = FETCH;
            fetch_next     = 1'b0;
            dec_valid_next = 1'b0;
            capture        = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= FETCH;
            o_pc        <= RESET_PC;
            o_fetch     <= 1'b0;
            o_dec_valid <= 1'b0;
            o_halted    <= 1'b0;
            o_op        <= 5'd0;
            o_cc        <= 3'd0;
            o_ra        <= 4'd0;
            o_rb        <= 4'd0;
            o_imm       <= 32'd0;
            o_len       <= 3'd0;
            o_dec_pc    <= 32'd0;
            o_illegal   <= 1'b0;
        end else begin
            state       <= state_next;
            o_pc        <= pc_next;
            o_fetch     <= fetch_next;
            o_dec_valid <= dec_valid_next;
            o_halted    <= (state_next == HALT);
            if (capture) begin
                o_op      <= i_instruction[47:43];
                o_cc      <= i_instruction[42:40];
                o_ra      <= i_instruction[39:36];
                o_rb      <= rb_dec;
                o_imm     <= imm_dec;
                o_len     <= len_dec;
                o_dec_pc  <= o_pc;
                o_illegal <= illegal_dec;
            end
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: inputs driven and outputs sampled on the falling clock edge.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch;
    logic [31:0] pc;
    logic [47:0] instruction;
    logic        valid, error, dec_valid, dec_ready;
    logic [4:0]  op;
    logic [2:0]  cc, len;
    logic [3:0]  ra, rb;
    logic [31:0] imm, dec_pc, jump_pc;
    logic        illegal, jump, halted;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    instr_decode #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_reset(rst_n), .o_fetch(fetch), .o_pc(pc),
        .i_instruction(instruction), .i_valid(valid), .i_error(error),
        .o_dec_valid(dec_valid), .i_dec_ready(dec_ready),
        .o_op(op), .o_cc(cc), .o_ra(ra), .o_rb(rb), .o_imm(imm), .o_len(len),
        .o_dec_pc(dec_pc), .o_illegal(illegal), .i_jump(jump), .i_jump_pc(jump_pc),
        .o_halted(halted)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the fetch pulse and checks its address.
    task automatic wait_fetch(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        while (fetch !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_fetch"}, {31'd0, fetch}, 32'd1);
        check_output({tag, "_pc"}, pc, exp_pc);
    endtask

    // Called at the negedge showing the fetch pulse; returns at the negedge showing the decode.
    task automatic apply_stimulus(input logic [47:0] instr);
        @(negedge clk);
        instruction = instr;
        valid       = 1'b1;
        @(negedge clk);
        valid       = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; instruction = '0; valid = 0; error = 0;
        dec_ready = 1'b1; jump = 0; jump_pc = '0;
        repeat (2) @(negedge clk);
        check_output("rst_fetch", {31'd0, fetch}, 32'd0);
        check_output("rst_pc", pc, 32'd0);
        check_output("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check_output("rst_halted", {31'd0, halted}, 32'd0);
        check_output("rst_fields", {op, cc, ra, rb, len, illegal, 12'd0}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check_output("first_fetch", {31'd0, fetch}, 32'd1);
        check_output("first_fetch_pc", pc, 32'd0);

        // amode 000
        apply_stimulus(48'h0800_0000_0000);
        check_output("a0_valid", {31'd0, dec_valid}, 32'd1);
        check_output("a0_op", {27'd0, op}, 32'd1);
        check_output("a0_len", {29'd0, len}, 32'd2);
        check_output("a0_imm", imm, 32'd0);
        check_output("a0_dec_pc", dec_pc, 32'd0);
        check_output("a0_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        check_output("a0_drop", {31'd0, dec_valid}, 32'd0);
        wait_fetch("a0_next", 32'd2);

        // amode 001 with execute stalled for five cycles
        dec_ready = 1'b0;
        apply_stimulus({5'd3, 3'd2, 4'd7, 3'b001, 1'b0, 16'h5FFF, 16'h0000});
        for (int i = 0; i < 5; i++) begin
            check_output("stall_valid", {31'd0, dec_valid}, 32'd1);
            check_output("stall_fetch", {31'd0, fetch}, 32'd0);
            check_output("stall_imm", imm, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        check_output("a1_fields", {16'd0, op, cc, ra, rb}, {16'd0, 5'd3, 3'd2, 4'd7, 4'd5});
        check_output("a1_len", {29'd0, len}, 32'd4);
        check_output("a1_dec_pc", dec_pc, 32'd2);
        dec_ready = 1'b1;
        @(negedge clk);
        check_output("a1_drop", {31'd0, dec_valid}, 32'd0);
        wait_fetch("a1_next", 32'd6);

        // amode 010: 28-bit field 0x8800001 sign-extends
        apply_stimulus({5'd2, 3'd0, 4'd1, 3'b010, 1'b0, 32'h3880_0001});
        check_output("a2_rb", {28'd0, rb}, 32'd3);
        check_output("a2_imm", imm, 32'hF880_0001);
        check_output("a2_len", {29'd0, len}, 32'd6);
        check_output("a2_dec_pc", dec_pc, 32'd6);
        @(negedge clk);
        wait_fetch("a2_next", 32'h0000_000C);

        // amode 011: full 32-bit immediate
        apply_stimulus({5'd4, 3'd1, 4'd2, 3'b011, 1'b0, 32'hDEAD_BEEF});
        check_output("a3_rb", {28'd0, rb}, 32'd0);
        check_output("a3_imm", imm, 32'hDEAD_BEEF);
        check_output("a3_len", {29'd0, len}, 32'd6);
        @(negedge clk);
        wait_fetch("a3_next", 32'h0000_0012);

        // redirect in WAIT; the stale i_valid from the old fetch must not decode
        @(negedge clk);
        jump = 1'b1; jump_pc = 32'h0000_0101;
        @(negedge clk);
        jump = 1'b0; valid = 1'b1; instruction = 48'h0800_0000_0000;
        check_output("jmp_valid", {31'd0, dec_valid}, 32'd0);
        check_output("jmp_pc", pc, 32'h0000_0100);
        @(negedge clk);
        check_output("jmp_fetch", {31'd0, fetch}, 32'd1);
        valid = 1'b0;
        @(negedge clk);
        check_output("jmp_stale", {31'd0, dec_valid}, 32'd0);

        // illegal amode, then transfer coincident with a jump
        apply_stimulus({5'd31, 3'd7, 4'd15, 3'b111, 33'h1_FFFF_FFFF});
        check_output("ill_valid", {31'd0, dec_valid}, 32'd1);
        check_output("ill_flag", {31'd0, illegal}, 32'd1);
        check_output("ill_fields", {16'd0, op, cc, ra, rb}, {16'd0, 5'd31, 3'd7, 4'd15, 4'd0});
        check_output("ill_len", {29'd0, len}, 32'd2);
        check_output("ill_imm", imm, 32'd0);
        check_output("ill_dec_pc", dec_pc, 32'h0000_0100);
        jump = 1'b1; jump_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        jump = 1'b0;
        check_output("xj_drop", {31'd0, dec_valid}, 32'd0);
        check_output("xj_pc", pc, 32'hFFFF_FFFE);
        wait_fetch("wrap_fetch", 32'hFFFF_FFFE);
        apply_stimulus(48'h0800_0000_0000);
        check_output("wrap_dec_pc", dec_pc, 32'hFFFF_FFFE);
        @(negedge clk);
        check_output("wrap_pc", pc, 32'd0);
        wait_fetch("wrap_next", 32'd0);

        // bus error wins over i_valid and i_jump in WAIT
        @(negedge clk);
        error = 1'b1; valid = 1'b1; jump = 1'b1; jump_pc = 32'h0000_0040;
        @(negedge clk);
        error = 1'b0; valid = 1'b0; jump = 1'b0;
        check_output("halt_flag", {31'd0, halted}, 32'd1);
        check_output("halt_valid", {31'd0, dec_valid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            jump = (i == 5);
            @(negedge clk);
            check_output("halt_fetch", {31'd0, fetch}, 32'd0);
            check_output("halt_pc", pc, 32'd0);
        end
        jump = 1'b0;
        check_output("halt_held", {31'd0, halted}, 32'd1);

        // asynchronous reset clears without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check_output("arst_halted", {31'd0, halted}, 32'd0);
        check_output("arst_op", {27'd0, op}, 32'd0);
        check_output("arst_pc", pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("restart_fetch", {31'd0, fetch}, 32'd1);
        check_output("restart_pc", pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
